// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Purpose:
//   Streams a program into instruction memory one byte at a time. Bytes arrive
//   in little-endian order over a valid/ready byte channel. Every four bytes are
//   packed into one 32-bit instruction word, and that word is written to
//   consecutive word-aligned addresses starting at 0. The CPU core is held in
//   reset until every requested word has been written.
//
// Handshake:
//   A byte moves only on a rising edge where byte_valid=1 and byte_ready=1.
//   The source must hold byte_data steady while byte_valid=1 and byte_ready=0.
//   byte_ready is high exactly while the loader is in LOAD.
//
// Ports:
//   clk         system clock, rising edge
//   n_rst       asynchronous active-low reset
//   start       one-cycle load request, honoured only in IDLE or DONE
//   num_words   number of words to load, sampled together with start
//   byte_valid  source has a byte on byte_data
//   byte_data   program byte
//   byte_ready  loader takes a byte this cycle
//   imem_we     one-cycle write strobe per assembled word
//   imem_addr   byte address of the word being written (word aligned)
//   imem_wdata  assembled instruction word
//   cpu_n_rst   active-low CPU reset, released only while DONE
//   busy        a load is in progress (LOAD or WRITE)
//   done        the program is fully loaded
//   error       sticky, set when the last start had an illegal num_words
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int NUM_INSTR = 32
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [5:0]  num_words,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_n_rst,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [6:0] MAX_WORDS = 7'(NUM_INSTR);

    state_t      state;
    state_t      state_next;

    logic [5:0]  count;
    logic [5:0]  word_idx;
    logic [1:0]  byte_idx;
    // Bytes 0..2 of the current word; byte 3 goes straight into wdata_q on the
    // same edge, so the full word is ready when WRITE begins.
    logic [23:0] buffer;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        error_q;

    logic        start_window;
    logic        start_ok;
    logic        byte_fire;
    logic        last_word;

    assign start_window = (state == IDLE) || (state == DONE);
    assign start_ok     = (num_words != 6'd0) && ({1'b0, num_words} <= MAX_WORDS);
    assign byte_fire    = byte_valid && (state == LOAD);
    assign last_word    = (6'(word_idx + 6'd1) == count);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    // A rejected start from DONE falls back to IDLE so the CPU
                    // goes back into reset.
                    state_next = start_ok ? LOAD : IDLE;
                end
            end
            LOAD: begin
                if (byte_fire && (byte_idx == 2'd3)) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = last_word ? DONE : LOAD;
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic (Moore, decoded from state)
    // -------------------------------------------------------------------------
    always_comb begin
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        cpu_n_rst  = 1'b0;
        case (state)
            LOAD: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            WRITE: begin
                imem_we = 1'b1;
                busy    = 1'b1;
            end
            DONE: begin
                done      = 1'b1;
                cpu_n_rst = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign error      = error_q;

    // -------------------------------------------------------------------------
    // Datapath: counters, byte packing, write address/data, error flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count    <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            buffer   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            if (start_window && start) begin
                if (start_ok) begin
                    count    <= num_words;
                    word_idx <= '0;
                    byte_idx <= '0;
                    error_q  <= 1'b0;
                end else begin
                    error_q  <= 1'b1;
                end
            end

            if (byte_fire) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0: buffer[7:0]   <= byte_data;
                    2'd1: buffer[15:8]  <= byte_data;
                    2'd2: buffer[23:16] <= byte_data;
                    default: begin
                        // Last byte: register the word and its address so they
                        // are presented during WRITE and held afterwards.
                        addr_q  <= {24'd0, word_idx, 2'b00};
                        wdata_q <= {byte_data, buffer};
                    end
                endcase
            end

            if ((state == WRITE) && !last_word) begin
                word_idx <= word_idx + 6'd1;
            end
        end
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: NUM_INSTR, default 32, instruction-memory depth in 32-bit words.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 n_rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  single-cycle request to begin a program load; sampled only in IDLE and DONE.
REQ-005 num_words  input  6  number of 32-bit words to load; sampled with start.
REQ-006 byte_valid  input  1  source presents a program byte on byte_data.
REQ-007 byte_data  input  8  program byte, little-endian stream order.
REQ-008 byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 imem_addr  output  32  byte address of the word being written, word-aligned.
REQ-011 imem_wdata  output  32  assembled instruction word.
REQ-012 cpu_n_rst  output  1  active-low reset to the CPU core; low while no valid program is present.
REQ-013 busy  output  1  load in progress.
REQ-014 done  output  1  program fully loaded; CPU released.
REQ-015 error  output  1  sticky flag: last start rejected for illegal num_words.

Function
REQ-016 States: IDLE, LOAD, WRITE, DONE; encoding free.
REQ-017 IDLE: byte_ready=0, imem_we=0, busy=0, done=0, cpu_n_rst=0.
REQ-018 IDLE/DONE + start, 1 <= num_words <= NUM_INSTR: latch count, clear word_idx, byte_idx, error; next state LOAD.
REQ-019 IDLE/DONE + start, num_words=0 or > NUM_INSTR: error=1 next cycle; next state IDLE (cpu_n_rst=0).
REQ-020 Byte transfer occurs only in a cycle with byte_valid=1 and byte_ready=1; byte_ready=1 exactly in LOAD.
REQ-021 Byte k (0..3) of a word lands in buffer bits [8k+7:8k]; byte_idx increments per transfer, wraps 3->0.
REQ-022 Transfer of byte 3: next state WRITE; buffer holds the full word.
REQ-023 WRITE (one cycle): imem_we=1, imem_addr={word_idx,2'b00} zero-extended, imem_wdata=buffer, byte_ready=0.
REQ-024 Latency: imem_we asserted the cycle after the 4th byte handshake.
REQ-025 Leaving WRITE: word_idx+1 == count -> DONE; otherwise word_idx increments, next state LOAD.
REQ-026 busy=1 in LOAD and WRITE only.
REQ-027 DONE: done=1, cpu_n_rst=1, byte_ready=0; held until next start.
REQ-028 start in LOAD or WRITE: ignored; no state or counter change.
REQ-029 byte_valid with byte_ready=0: byte not consumed; source holds it (no loss, no duplication).
REQ-030 Restart from DONE: cpu_n_rst drops to 0 in the same edge that enters LOAD; no partial program ever runs.
REQ-031 imem_addr and imem_wdata outside WRITE: hold last written values (don't-care for memory since imem_we=0).

Reset
REQ-032 n_rst low: state IDLE, counters 0, buffer 0, all outputs 0 (cpu_n_rst=0, imem_addr=0, imem_wdata=0) immediately, independent of clk.
REQ-033 n_rst low mid-LOAD or mid-WRITE: load aborted, no further imem_we; partial word discarded.
REQ-034 After n_rst release: first start accepted on the first rising edge.

Verification
REQ-035 start, num_words=1, bytes 0x93,0x00,0x50,0x00 back-to-back -> one imem_we, addr 0x0, wdata 0x00500093; done=1, cpu_n_rst=1 next cycle.
REQ-036 num_words=3, byte_valid toggling every other cycle -> exactly 3 writes at addr 0x0, 0x4, 0x8 with correct words; no byte lost or duplicated; busy high throughout.
REQ-037 start with num_words=0, then num_words=33 (NUM_INSTR=32) -> error=1, state IDLE, no imem_we, cpu_n_rst=0; then valid start clears error.
REQ-038 n_rst asserted after 2 bytes of word 1 -> outputs 0 asynchronously; after release, fresh load of 1 word writes addr 0x0 with new data only.
REQ-039 Load 2 words to DONE, then start with num_words=1 -> cpu_n_rst falls on start edge, one write at addr 0x0, done again.
REQ-040 start pulsed during LOAD -> ignored; load completes with original count.
